// File: rtl/psl_mmio_pkg.sv
// Shared types and constants for the PSL-side MMIO initiator.
package psl_mmio_pkg;

  localparam int MMAD_W   = 24;
  localparam int MMDATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RESP
  } state_t;

  // CAPI buses carry odd parity: ones(data) + par is always odd.
  function automatic logic odd_parity(input logic [0:MMDATA_W-1] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/psl_mmio_if.sv
// CAPI MMIO bus between the PSL (master) and the AFU (slave).
interface psl_mmio_if;
  import psl_mmio_pkg::*;

  logic                  ha_mmval;
  logic                  ha_mmcfg;
  logic                  ha_mmrnw;
  logic                  ha_mmdw;
  logic [0:MMAD_W-1]     ha_mmad;
  logic                  ha_mmadpar;
  logic [0:MMDATA_W-1]   ha_mmdata;
  logic                  ha_mmdatapar;
  logic                  ah_mmack;
  logic [0:MMDATA_W-1]   ah_mmdata;
  logic                  ah_mmdatapar;

  modport master (
    output ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw,
    output ha_mmad, ha_mmadpar, ha_mmdata, ha_mmdatapar,
    input  ah_mmack, ah_mmdata, ah_mmdatapar
  );

  modport slave (
    input  ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw,
    input  ha_mmad, ha_mmadpar, ha_mmdata, ha_mmdatapar,
    output ah_mmack, ah_mmdata, ah_mmdatapar
  );

endinterface

// File: rtl/capi_odd_parity.sv
// Combinational odd-parity generator (XNOR-reduce) of configurable width.
module capi_odd_parity #(
  parameter int W = 8
) (
  input  logic [0:W-1] data,
  output logic         par
);

  assign par = ~^data;

endmodule

// File: rtl/psl_mmio_master.sv
// PSL-side MMIO initiator: one host request at a time onto the CAPI MMIO bus.
// Optional read-data parity checking is enabled by defining PSL_MMIO_PARCHK_EN.
module psl_mmio_master
  import psl_mmio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                ha_pclock,
  input  logic                ha_preset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rnw,
  input  logic                req_dw,
  input  logic                req_cfg,
  input  logic [0:MMAD_W-1]   req_addr,
  input  logic [0:MMDATA_W-1] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [0:MMDATA_W-1] rsp_rdata,
  output logic                rsp_timeout,
  output logic                rsp_align_err,
  output logic                rsp_parerr,
  output logic                stray_ack,
  psl_mmio_if.master          mm
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                align_bad;
  logic [0:MMDATA_W-1] wdata_nxt;
  logic                ad_par_nxt;
  logic                data_par_nxt;
  logic [0:MMDATA_W-1] rd_capture;
  logic                rd_par_bad;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign align_bad = req_dw && req_addr[MMAD_W-1];
  // Word writes replicate the low word so either half of the bus can be used by the AFU.
  assign wdata_nxt = req_dw ? req_wdata : {req_wdata[32:63], req_wdata[32:63]};
  assign rd_capture = mm.ha_mmdw ? mm.ah_mmdata : {32'h0, mm.ah_mmdata[32:63]};

  capi_odd_parity #(.W(MMAD_W))   u_ad_par   (.data(req_addr),  .par(ad_par_nxt));
  capi_odd_parity #(.W(MMDATA_W)) u_data_par (.data(wdata_nxt), .par(data_par_nxt));

`ifdef PSL_MMIO_PARCHK_EN
  logic rd_par_exp;
  capi_odd_parity #(.W(MMDATA_W)) u_rd_par (.data(mm.ah_mmdata), .par(rd_par_exp));
  assign rd_par_bad = (rd_par_exp != mm.ah_mmdatapar);
`else
  assign rd_par_bad = 1'b0;
`endif

  always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
    if (!ha_preset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_timeout     <= 1'b0;
      rsp_align_err   <= 1'b0;
      rsp_parerr      <= 1'b0;
      stray_ack       <= 1'b0;
      mm.ha_mmval     <= 1'b0;
      mm.ha_mmcfg     <= 1'b0;
      mm.ha_mmrnw     <= 1'b0;
      mm.ha_mmdw      <= 1'b0;
      mm.ha_mmad      <= '0;
      mm.ha_mmadpar   <= 1'b0;
      mm.ha_mmdata    <= '0;
      mm.ha_mmdatapar <= 1'b0;
    end else begin
      if (mm.ah_mmack && state != WAIT_ACK) begin
        stray_ack <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            // Misaligned doublewords never reach the bus.
            if (align_bad) begin
              state         <= RESP;
              rsp_valid     <= 1'b1;
              rsp_align_err <= 1'b1;
              rsp_rdata     <= '0;
            end else begin
              state           <= ISSUE;
              mm.ha_mmval     <= 1'b1;
              mm.ha_mmcfg     <= req_cfg;
              mm.ha_mmrnw     <= req_rnw;
              mm.ha_mmdw      <= req_dw;
              mm.ha_mmad      <= req_addr;
              mm.ha_mmadpar   <= ad_par_nxt;
              mm.ha_mmdata    <= wdata_nxt;
              mm.ha_mmdatapar <= data_par_nxt;
            end
          end
        end
        ISSUE: begin
          mm.ha_mmval <= 1'b0;
          cnt         <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (mm.ah_mmack) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            if (mm.ha_mmrnw) begin
              rsp_rdata  <= rd_capture;
              rsp_parerr <= rd_par_bad;
            end
          end else if (cnt == CNT_LAST) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state         <= IDLE;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_timeout   <= 1'b0;
            rsp_align_err <= 1'b0;
            rsp_parerr    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
